// File: rtl/pipe_reg.sv
// pipe_reg: elastic DEPTH-stage WIDTH-bit register pipeline with valid/ready, bubble collapse, sync flush.
// Latency: a beat accepted at edge N is on d_out/valid_out after edge N+DEPTH-1; 1 beat/cycle sustained.
// Backpressure: stages hold when blocked, empty stages always fill; ready_out ripples back from ready_in.
// Optional occupancy output count_out is built when PIPE_REG_COUNT_EN is defined.
module pipe_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] d_out,
  output logic             valid_out,
  input  logic             ready_in
`ifdef PIPE_REG_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count_out
`endif
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] in_dat [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] in_vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;

  // Advance enables: a stage moves if it is empty or the stage after it moves.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !valid_q[DEPTH-1] || ready_in;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end
  end

  // Next state per stage: valid follows the upstream flag, data only loads on a real beat.
  always_comb begin
    in_vld    = '0;
    in_vld[0] = valid_in;
    in_dat[0] = d_in;
    for (int k = 1; k < DEPTH; k++) begin
      in_vld[k] = valid_q[k-1];
      in_dat[k] = data_q[k-1];
    end
    load = adv & in_vld & {DEPTH{!flush_in}};
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = flush_in ? 1'b0 : (adv[k] ? in_vld[k] : valid_q[k]);
      data_d[k]  = load[k] ? in_dat[k] : data_q[k];
    end
  end

  // Stage registers; flush only clears the valid flags, data is left in place.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign ready_out = adv[0] && !flush_in;
  assign d_out     = data_q[DEPTH-1];
  assign valid_out = valid_q[DEPTH-1];

`ifdef PIPE_REG_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          up_xfer;
  logic          dn_xfer;

  // Occupancy tracks transfers; a flushed output beat is not a delivery.
  always_comb begin
    up_xfer = valid_in && ready_out;
    dn_xfer = valid_out && ready_in && !flush_in;
    count_d = count_q;
    if (flush_in) begin
      count_d = '0;
    end else if (up_xfer && !dn_xfer) begin
      count_d = count_q + CW'(1);
    end else if (dn_xfer && !up_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed checks on a DEPTH=2/WIDTH=8 pipe plus a randomised scoreboard
// sweep over DEPTH=3/WIDTH=32, DEPTH=1/WIDTH=1 and DEPTH=4/WIDTH=8 instances.
module tb_pipe_reg;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Main directed instance.
  logic       flush_a, valid_a, ready_a, rdy_a, vout_a;
  logic [7:0] d_a, q_a;

  // Sweep instances share valid/ready stimulus.
  logic        valid_r, ready_r;
  logic [31:0] d_b, q_b;
  logic [0:0]  d_c, q_c;
  logic [7:0]  d_d, q_d;
  logic        rdy_b, rdy_c, rdy_d, vo_b, vo_c, vo_d;

`ifdef PIPE_REG_COUNT_EN
  logic [1:0] cnt_a;
  logic [1:0] cnt_b;
  logic [0:0] cnt_c;
  logic [2:0] cnt_d;
  int         cnt_r [3];
  assign cnt_r[0] = int'(cnt_b);
  assign cnt_r[1] = int'(cnt_c);
  assign cnt_r[2] = int'(cnt_d);
`endif

  logic [31:0] q_r   [3];
  logic        rdy_r [3];
  logic        vo_r  [3];
  assign q_r[0] = q_b;
  assign q_r[1] = {31'b0, q_c};
  assign q_r[2] = {24'b0, q_d};
  assign rdy_r[0] = rdy_b;
  assign rdy_r[1] = rdy_c;
  assign rdy_r[2] = rdy_d;
  assign vo_r[0] = vo_b;
  assign vo_r[1] = vo_c;
  assign vo_r[2] = vo_d;

  localparam int          DEP  [3] = '{3, 1, 4};
  localparam logic [31:0] MASK [3] = '{32'hFFFF_FFFF, 32'h1, 32'hFF};

  logic [31:0] tag [3];
  logic [31:0] sb  [3][$];

  pipe_reg #(.WIDTH(8), .DEPTH(2)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush_a), .d_in(d_a), .valid_in(valid_a),
    .ready_out(rdy_a), .d_out(q_a), .valid_out(vout_a), .ready_in(ready_a)
`ifdef PIPE_REG_COUNT_EN
    , .count_out(cnt_a)
`endif
  );

  pipe_reg #(.WIDTH(32), .DEPTH(3)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(1'b0), .d_in(d_b), .valid_in(valid_r),
    .ready_out(rdy_b), .d_out(q_b), .valid_out(vo_b), .ready_in(ready_r)
`ifdef PIPE_REG_COUNT_EN
    , .count_out(cnt_b)
`endif
  );

  pipe_reg #(.WIDTH(1), .DEPTH(1)) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(1'b0), .d_in(d_c), .valid_in(valid_r),
    .ready_out(rdy_c), .d_out(q_c), .valid_out(vo_c), .ready_in(ready_r)
`ifdef PIPE_REG_COUNT_EN
    , .count_out(cnt_c)
`endif
  );

  pipe_reg #(.WIDTH(8), .DEPTH(4)) u_d (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(1'b0), .d_in(d_d), .valid_in(valid_r),
    .ready_out(rdy_d), .d_out(q_d), .valid_out(vo_d), .ready_in(ready_r)
`ifdef PIPE_REG_COUNT_EN
    , .count_out(cnt_d)
`endif
  );

  task automatic check(input string tag_s, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag_s, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_v;
    rst_n   = 1'b0;
    flush_a = 1'b0;
    valid_a = 1'b0;
    ready_a = 1'b0;
    d_a     = 8'h00;
    valid_r = 1'b0;
    ready_r = 1'b0;
    d_b     = '0;
    d_c     = '0;
    d_d     = '0;
    for (int i = 0; i < 3; i++) tag[i] = 32'd100 * 32'(i + 1);

    // Reset values
    #12;
    check("rst_vout", {31'b0, vout_a}, 0);
    check("rst_dout", {24'b0, q_a}, 32'h00);
`ifdef PIPE_REG_COUNT_EN
    check("rst_cnt", {30'b0, cnt_a}, 0);
`endif
    #1 rst_n = 1'b1;
    #1 check("rst_rdy", {31'b0, rdy_a}, 1);
    tick();

    // Streaming 01..08 with ready_in high
    ready_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      valid_a = 1'b1;
      d_a     = 8'(i);
      #1 check("stream_rdy", {31'b0, rdy_a}, 1);
      tick();
      if (i >= 2) begin
        check("stream_vld", {31'b0, vout_a}, 1);
        check("stream_dat", {24'b0, q_a}, 32'(i - 1));
`ifdef PIPE_REG_COUNT_EN
        check("stream_cnt", {30'b0, cnt_a}, 2);
`endif
      end
    end
    valid_a = 1'b0;
    tick();
    check("stream_last", {23'b0, vout_a, q_a}, 32'h108);
    tick();
    check("stream_empty", {31'b0, vout_a}, 0);

    // Back-pressure: fill with A1, A2, then accept A3 while draining
    ready_a = 1'b0;
    valid_a = 1'b1;
    d_a     = 8'hA1;
    tick();
    d_a = 8'hA2;
    tick();
    d_a = 8'hA3;
    #1;
    check("bp_rdy_full", {31'b0, rdy_a}, 0);
    check("bp_dat", {23'b0, vout_a, q_a}, 32'h1A1);
`ifdef PIPE_REG_COUNT_EN
    check("bp_cnt", {30'b0, cnt_a}, 2);
`endif
    tick();
    check("bp_hold", {23'b0, vout_a, q_a}, 32'h1A1);
    check("bp_hold_rdy", {31'b0, rdy_a}, 0);
    ready_a = 1'b1;
    #1 check("bp_full_drain_rdy", {31'b0, rdy_a}, 1);
    tick();
    check("bp_second", {23'b0, vout_a, q_a}, 32'h1A2);
`ifdef PIPE_REG_COUNT_EN
    check("bp_cnt_same", {30'b0, cnt_a}, 2);
`endif
    valid_a = 1'b0;
    tick();
    check("bp_third", {23'b0, vout_a, q_a}, 32'h1A3);
    tick();
    check("bp_empty", {31'b0, vout_a}, 0);

    // Bubbles: 11, (55 invalid), 22 while stalled
    ready_a = 1'b0;
    valid_a = 1'b1;
    d_a     = 8'h11;
    tick();
    valid_a = 1'b0;
    d_a     = 8'h55;
    tick();
    valid_a = 1'b1;
    d_a     = 8'h22;
    tick();
    valid_a = 1'b0;
    #1;
    check("bub_rdy", {31'b0, rdy_a}, 0);
    check("bub_first", {23'b0, vout_a, q_a}, 32'h111);
`ifdef PIPE_REG_COUNT_EN
    check("bub_cnt", {30'b0, cnt_a}, 2);
`endif
    ready_a = 1'b1;
    tick();
    check("bub_second", {23'b0, vout_a, q_a}, 32'h122);
    tick();
    check("bub_empty", {31'b0, vout_a}, 0);

    // X on d_in with valid_in low must not reach d_out
    d_a = 8'bx;
    tick();
    tick();
    check("xsafe_dat", {24'b0, q_a}, 32'h22);
    check("xsafe_vld", {31'b0, vout_a}, 0);
    d_a = 8'h00;

    // Flush with a full pipe and a beat presented
    ready_a = 1'b0;
    valid_a = 1'b1;
    d_a     = 8'h33;
    tick();
    d_a = 8'h44;
    tick();
    flush_a = 1'b1;
    d_a     = 8'hFF;
    ready_a = 1'b1;
    #1 check("flush_rdy", {31'b0, rdy_a}, 0);
    tick();
    flush_a = 1'b0;
    valid_a = 1'b0;
    #1;
    check("flush_vld", {31'b0, vout_a}, 0);
    check("flush_data_kept", {24'b0, q_a}, 32'h33);
`ifdef PIPE_REG_COUNT_EN
    check("flush_cnt", {30'b0, cnt_a}, 0);
`endif
    tick();
    check("flush_vld2", {31'b0, vout_a}, 0);
    valid_a = 1'b1;
    d_a     = 8'h5A;
    tick();
    valid_a = 1'b0;
    tick();
    check("post_flush", {23'b0, vout_a, q_a}, 32'h15A);
    tick();

    // Asynchronous reset while full
    ready_a = 1'b0;
    valid_a = 1'b1;
    d_a     = 8'h66;
    tick();
    d_a = 8'h77;
    tick();
    valid_a = 1'b0;
    #1 check("mrst_pre", {23'b0, vout_a, q_a}, 32'h166);
    rst_n = 1'b0;
    #1;
    check("mrst_vld", {31'b0, vout_a}, 0);
    check("mrst_dat", {24'b0, q_a}, 32'h00);
`ifdef PIPE_REG_COUNT_EN
    check("mrst_cnt", {30'b0, cnt_a}, 0);
`endif
    #1 rst_n = 1'b1;
    tick();
    check("mrst_rdy", {31'b0, rdy_a}, 1);
    check("mrst_vld2", {31'b0, vout_a}, 0);

    // Randomised sweep with per-instance scoreboards, then drain
    for (int cyc = 0; cyc < 600; cyc++) begin
      valid_r = ($urandom_range(0, 3) != 0);
      ready_r = ($urandom_range(0, 2) != 0);
      if (cyc >= 560) begin
        valid_r = 1'b0;
        ready_r = 1'b1;
      end
      d_b = tag[0];
      d_c = tag[1][0];
      d_d = tag[2][7:0];
      #1;
      for (int i = 0; i < 3; i++) begin
`ifdef PIPE_REG_COUNT_EN
        check("sweep_cnt", cnt_r[i], sb[i].size());
        check("sweep_cnt_max", {31'b0, cnt_r[i] <= DEP[i]}, 1);
`endif
        if (vo_r[i] && ready_r) begin
          if (sb[i].size() == 0) begin
            check("sweep_spurious", {31'b0, vo_r[i]}, 0);
          end else begin
            exp_v = sb[i].pop_front();
            check("sweep_data", q_r[i], exp_v);
          end
        end
        if (valid_r && rdy_r[i]) begin
          sb[i].push_back(tag[i] & MASK[i]);
          tag[i] = tag[i] + 32'd1;
        end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      check("sweep_left", sb[i].size(), 0);
      check("sweep_vout", {31'b0, vo_r[i]}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised, elastic, enable-gated register pipeline: DEPTH stages of WIDTH-bit storage with valid/ready handshake, bubble collapsing and synchronous flush.
- Edge-triggered generalisation of the enable-hold storage element (hold when not enabled, load when enabled); the per-stage enable is derived from the handshake.
- Used between datapath blocks to add registered latency while tolerating downstream back-pressure.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 2, number of register stages (>=1); DEPTH=1 is a single handshaked register

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- flush_in  input  1  synchronous flush; clears all stages
- d_in  input  WIDTH  upstream data
- valid_in  input  1  upstream data valid
- ready_out  output  1  pipe can accept d_in this cycle
- d_out  output  WIDTH  data of last stage
- valid_out  output  1  last stage holds valid data
- ready_in  input  1  downstream accepts d_out this cycle

Behaviour:
- Storage: per stage k (0 = input side, DEPTH-1 = output side), one data register and one valid flag.
- d_out = data[DEPTH-1]; valid_out = valid[DEPTH-1]. Both are registered, with no combinational path from d_in or valid_in.
- Reset (rst_n_in low, asynchronous): all valid flags = 0; all data registers = 0. Therefore valid_out = 0, d_out = 0, and ready_out = 1 once reset is released.
- Advance enables, evaluated combinationally from the output side back:
  - adv[DEPTH-1] = !valid[DEPTH-1] || ready_in
  - adv[k] = !valid[k] || adv[k+1]
- Stage load on a clock edge with adv[k] = 1:
  - Stage 0: data[0] <= d_in, valid[0] <= valid_in.
  - Stage k>0: data[k] <= data[k-1], valid[k] <= valid[k-1].
- Stage hold: when adv[k] = 0, data[k] and valid[k] are unchanged.
- Data registers load only when the stage advances AND its incoming valid is 1. Bubbles never overwrite data; this avoids unnecessary toggles.
- ready_out = adv[0] && !flush_in. This is a combinational path from ready_in (ripple through the valid chain); it is accepted by design.
- Transfers:
  - Upstream transfer = valid_in && ready_out.
  - Downstream transfer = valid_out && ready_in.
- Latency: a beat accepted at edge N appears on valid_out after edge N+DEPTH-1, assuming no stall. Throughput is 1 beat/cycle when ready_in stays high.
- Bubble collapse: an empty stage always accepts, so a stalled output can fill all DEPTH stages. Capacity is DEPTH beats.
- Full: all valid = 1 and ready_in = 0 -> ready_out = 0; d_out and valid_out stay stable until ready_in rises.
- Stability rule: while valid_out = 1 and ready_in = 0, d_out must not change.
- Simultaneous accept and drain while full: ready_in = 1 -> every stage advances and ready_out = 1 in the same cycle; occupancy is unchanged.
- Flush (flush_in high at an edge):
  - All valid flags <= 0; data registers are unchanged.
  - The beat presented on d_in in that cycle is dropped.
  - ready_out = 0 during that cycle.
  - The beat on d_out in that cycle is considered not transferred, even if ready_in = 1.
- Reset mid-operation: all in-flight beats are lost. There is no partial state, and valid_out deasserts immediately (asynchronously).
- X-safety: an X on d_in while valid_in = 0 must never propagate to d_out.

Optional Feature:
- Macro: PIPE_REG_COUNT_EN.
- Defined:
  - Adds output count_out, width $clog2(DEPTH+1), equal to the number of set valid flags (0..DEPTH).
  - count_out is registered: reset value 0, cleared to 0 by flush_in.
  - Update rule: +1 on an upstream-only transfer, -1 on a downstream-only transfer, unchanged when both or neither occur.
  - Must always equal the popcount of the valid flags.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, DEPTH=2, WIDTH=8: rst_n_in low mid-cycle -> valid_out=0 and d_out=8'h00 immediately; after release, ready_out=1.
- Streaming: ready_in=1, valid_in=1, d_in=8'h01..8'h08 on consecutive edges -> d_out=8'h01 valid one cycle after its acceptance edge, then 8'h02..8'h08 on successive cycles, no gaps.
- Back-pressure: ready_in=0 and push 8'hA1, 8'hA2 -> ready_out=0 after 2 accepts; d_out holds 8'hA1; raise ready_in -> 8'hA1 then 8'hA2 delivered in order, none lost or duplicated.
- Bubbles: valid_in pattern 1,0,1 with d_in=8'h11,8'h55,8'h22 and ready_in=0 -> both valid beats (8'h11, 8'h22) are stored and 8'h55 is never seen on d_out; count_out=2 when the macro is defined.
- Flush: pipe holding 2 beats, flush_in=1 with valid_in=1, d_in=8'hFF -> next cycle valid_out=0; 8'hFF is never delivered; count_out=0.
- Parameter sweep: DEPTH=1,3,4 and WIDTH=1,32 with a randomised valid_in/ready_in scoreboard run -> in-order, lossless delivery; count_out never exceeds DEPTH.
